// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// FSM state encoding and two-word AVR opcode masks.
package fetch_pkg;

    localparam int PC_W_DEFAULT = 14;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    // JMP 1001_010x_xxxx_110x, CALL 1001_010x_xxxx_111x
    localparam logic [15:0] JMP_MASK   = 16'hFE0E;
    localparam logic [15:0] JMP_MATCH  = 16'h940C;
    localparam logic [15:0] CALL_MASK  = 16'hFE0E;
    localparam logic [15:0] CALL_MATCH = 16'h940E;

    // LDS 1001_000x_xxxx_0000, STS 1001_001x_xxxx_0000
    localparam logic [15:0] LDS_MASK   = 16'hFE0F;
    localparam logic [15:0] LDS_MATCH  = 16'h9000;
    localparam logic [15:0] STS_MASK   = 16'hFE0F;
    localparam logic [15:0] STS_MATCH  = 16'h9200;

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_ISSUE = 2'd1,
        S_WORD2 = 2'd2,
        S_HOLD  = 2'd3
    } fseq_state_e;

    function automatic logic op_match(
        input logic [15:0] word,
        input logic [15:0] mask,
        input logic [15:0] value
    );
        return (word & mask) == value;
    endfunction

endpackage

// File: rtl/fetch_sequencer_two_word_detect.sv
// Flags AVR instructions that carry a second (extension) word:
// JMP, CALL, LDS and STS.
module two_word_detect
    import fetch_pkg::*;
(
    input  logic [15:0] i_word,
    output logic        o_is_two_word
);

    logic w_jmp;
    logic w_call;
    logic w_lds;
    logic w_sts;

    assign w_jmp  = op_match(i_word, JMP_MASK, JMP_MATCH);
    assign w_call = op_match(i_word, CALL_MASK, CALL_MATCH);
    assign w_lds  = op_match(i_word, LDS_MASK, LDS_MATCH);
    assign w_sts  = op_match(i_word, STS_MASK, STS_MATCH);

    assign o_is_two_word = w_jmp | w_call | w_lds | w_sts;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: flushes, two-word assembly, hold and IRQ vectors.
// Interrupt path is compiled in only when FETCH_IRQ_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int FLUSH_CYCLES = 1,
    parameter int VEC_STRIDE   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     instruction,
    input  logic [PC_W-1:0] program_counter,
    input  logic            exec_busy,
    input  logic            branch_req,
    input  logic [PC_W-1:0] branch_target,
    input  logic            irq_req,
    input  logic [4:0]      irq_num,
    input  logic            global_ie,
    output logic            instruction_running,
    output logic            PC_overwrite,
    output logic [PC_W-1:0] PC_new,
    output logic            issue_valid,
    output logic [15:0]     issue_instr,
    output logic [15:0]     issue_ext,
    output logic [PC_W-1:0] issue_pc,
    output logic            irq_ack,
    output logic [PC_W-1:0] irq_ret_pc
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    fseq_state_e     r_state;
    logic [1:0]      r_flush_cnt;
    logic [15:0]     r_hold_word;
    logic [PC_W-1:0] r_hold_pc;

    logic            w_two_word;
    logic            w_decide;
    logic            w_irq_take;
    logic [PC_W-1:0] w_cur_pc;
    logic [PC_W-1:0] w_vec_pc;

    // The I-reg always lags the PC by one word.
    assign w_cur_pc = program_counter - PC_W'(1);

    // HOLD behaves exactly like ISSUE: the preserved I-reg is re-decided.
    assign w_decide = (r_state == S_ISSUE) || (r_state == S_HOLD);

`ifdef FETCH_IRQ_EN
    localparam logic [31:0] STRIDE = 32'(VEC_STRIDE);

    assign w_irq_take = irq_req & global_ie & ~exec_busy;
    assign w_vec_pc   = PC_W'(32'(irq_num) * STRIDE);
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{irq_req, irq_num, global_ie};
    assign w_irq_take   = 1'b0;
    assign w_vec_pc     = '0;
`endif

    two_word_detect u_detect (
        .i_word        (instruction),
        .o_is_two_word (w_two_word)
    );

    always_comb begin
        instruction_running = 1'b0;
        PC_overwrite        = 1'b0;
        PC_new              = '0;
        issue_valid         = 1'b0;
        issue_instr         = NOP_WORD;
        issue_ext           = NOP_WORD;
        issue_pc            = '0;
        irq_ack             = 1'b0;
        irq_ret_pc          = '0;
        if (w_decide) begin
            if (branch_req) begin
                PC_overwrite = 1'b1;
                PC_new       = branch_target;
            end else if (w_irq_take) begin
                PC_overwrite = 1'b1;
                PC_new       = w_vec_pc;
                irq_ack      = 1'b1;
                irq_ret_pc   = w_cur_pc;
            end else if (exec_busy) begin
                instruction_running = 1'b1;
            end else if (!w_two_word) begin
                issue_valid = 1'b1;
                issue_instr = instruction;
                issue_pc    = w_cur_pc;
            end
        end else if (r_state == S_WORD2) begin
            if (exec_busy) begin
                instruction_running = 1'b1;
            end else begin
                issue_valid = 1'b1;
                issue_instr = r_hold_word;
                issue_ext   = instruction;
                issue_pc    = r_hold_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= FLUSH_INIT;
            r_hold_word <= NOP_WORD;
            r_hold_pc   <= '0;
        end else begin
            unique case (r_state)
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - 2'd1;
                    if (r_flush_cnt <= 2'd1) begin
                        r_flush_cnt <= 2'd0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE, S_HOLD: begin
                    if (branch_req || w_irq_take) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= FLUSH_INIT;
                    end else if (exec_busy) begin
                        r_state <= S_HOLD;
                    end else if (w_two_word) begin
                        r_hold_word <= instruction;
                        r_hold_pc   <= w_cur_pc;
                        r_state     <= S_WORD2;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_WORD2: begin
                    if (!exec_busy) begin
                        r_state <= S_ISSUE;
                    end
                end
                default: begin
                    r_state     <= S_FLUSH;
                    r_flush_cnt <= FLUSH_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: fetch-stage model, program-flow reference model,
// directed vectors. Define FETCH_IRQ_EN to exercise the interrupt path.
module tb_fetch_sequencer;

    localparam int PC_W    = 14;
    localparam int FLUSH_N = 1;
    localparam int STRIDE  = 2;
`ifdef FETCH_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            exec_busy;
    logic            branch_req;
    logic [13:0]     branch_target;
    logic            irq_req;
    logic [4:0]      irq_num;
    logic            global_ie;
    logic            instruction_running;
    logic            PC_overwrite;
    logic [13:0]     PC_new;
    logic            issue_valid;
    logic [15:0]     issue_instr;
    logic [15:0]     issue_ext;
    logic [13:0]     issue_pc;
    logic            irq_ack;
    logic [13:0]     irq_ret_pc;

    logic [15:0]     mem [0:16383];
    logic [13:0]     pc_q;
    logic [15:0]     ireg_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FLUSH_N),
        .VEC_STRIDE   (STRIDE)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .instruction         (ireg_q),
        .program_counter     (pc_q),
        .exec_busy           (exec_busy),
        .branch_req          (branch_req),
        .branch_target       (branch_target),
        .irq_req             (irq_req),
        .irq_num             (irq_num),
        .global_ie           (global_ie),
        .instruction_running (instruction_running),
        .PC_overwrite        (PC_overwrite),
        .PC_new              (PC_new),
        .issue_valid         (issue_valid),
        .issue_instr         (issue_instr),
        .issue_ext           (issue_ext),
        .issue_pc            (issue_pc),
        .irq_ack             (irq_ack),
        .irq_ret_pc          (irq_ret_pc)
    );

    // Fetch stage: program memory, PC and I-reg
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            ireg_q <= '0;
        end else if (PC_overwrite) begin
            ireg_q <= mem[pc_q];
            pc_q   <= PC_new;
        end else if (!instruction_running) begin
            ireg_q <= mem[pc_q];
            pc_q   <= pc_q + 14'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_two(input logic [15:0] w);
        logic [6:0] op;
        op = w[15:9];
        if (op == 7'b1001010 && w[3:2] == 2'b11) return 1'b1;
        if ((op == 7'b1001000 || op == 7'b1001001) && w[3:0] == 4'd0)
            return 1'b1;
        return 1'b0;
    endfunction

    // Reference: flush budget left, and a queue of first words awaiting
    // their extension word.
    int          m_flush = FLUSH_N;
    logic [15:0] q_w [$];
    logic [13:0] q_pc [$];
    int          n_flush;
    bit          m_upd, do_push, do_pop;
    bit          e_run, e_ow, e_v, e_ack;
    logic [13:0] e_pcn, e_ip, e_ret, cur;
    logic [15:0] e_i, e_x;

    always begin
        @(negedge clk);
        #2;
        m_upd = 1'b0;
        if (!reset_n) begin
            check("reset_zero", 32'(|{instruction_running, PC_overwrite,
                  PC_new, issue_valid, issue_instr, issue_ext, issue_pc,
                  irq_ack, irq_ret_pc}), 32'd0);
        end else begin
            e_run = 0; e_ow = 0; e_v = 0; e_ack = 0;
            e_pcn = 0; e_ip = 0; e_ret = 0; e_i = 0; e_x = 0;
            do_push = 0; do_pop = 0;
            n_flush = m_flush;
            cur = pc_q - 14'd1;
            if (m_flush > 0) begin
                n_flush = m_flush - 1;
            end else if (q_w.size() > 0) begin
                if (exec_busy) e_run = 1;
                else begin
                    e_v = 1; e_i = q_w[0]; e_x = ireg_q; e_ip = q_pc[0];
                    do_pop = 1;
                end
            end else if (branch_req) begin
                e_ow = 1; e_pcn = branch_target; n_flush = FLUSH_N;
            end else if (IRQ_ON && irq_req && global_ie && !exec_busy) begin
                e_ow = 1; e_pcn = 14'(int'(irq_num) * STRIDE);
                e_ack = 1; e_ret = cur; n_flush = FLUSH_N;
            end else if (exec_busy) begin
                e_run = 1;
            end else if (is_two(ireg_q)) begin
                do_push = 1;
            end else begin
                e_v = 1; e_i = ireg_q; e_ip = cur;
            end
            check("m_run", 32'(instruction_running), 32'(e_run));
            check("m_ovw", 32'(PC_overwrite), 32'(e_ow));
            check("m_valid", 32'(issue_valid), 32'(e_v));
            check("m_ack", 32'(irq_ack), 32'(e_ack));
            check("m_excl", 32'(PC_overwrite & instruction_running), 32'd0);
            if (e_ow) check("m_pcnew", 32'(PC_new), 32'(e_pcn));
            if (e_v) begin
                check("m_instr", 32'(issue_instr), 32'(e_i));
                check("m_ext", 32'(issue_ext), 32'(e_x));
                check("m_ipc", 32'(issue_pc), 32'(e_ip));
            end
            if (e_ack || !IRQ_ON) check("m_ret", 32'(irq_ret_pc), 32'(e_ret));
            m_upd = 1'b1;
        end
        @(posedge clk);
        if (!reset_n) begin
            m_flush = FLUSH_N;
            q_w.delete();
            q_pc.delete();
        end else if (m_upd) begin
            m_flush = n_flush;
            if (do_push) begin
                q_w.push_back(ireg_q);
                q_pc.push_back(cur);
            end
            if (do_pop) begin
                void'(q_w.pop_front());
                void'(q_pc.pop_front());
            end
        end
    end

    task automatic step(input bit busy, input bit br, input logic [13:0] tgt,
                        input bit irq, input logic [4:0] num, input bit ie);
        @(negedge clk);
        exec_busy     = busy;
        branch_req    = br;
        branch_target = tgt;
        irq_req       = irq;
        irq_num       = num;
        global_ie     = ie;
        #3;
    endtask

    task automatic idle();
        step(0, 0, 14'd0, 0, 5'd0, 0);
    endtask

    initial begin
        reset_n = 1'b1;
        exec_busy = 0; branch_req = 0; branch_target = 0;
        irq_req = 0; irq_num = 0; global_ie = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[1]  = 16'hE005;
        mem[3]  = 16'h2311;
        mem[4]  = 16'h940C;
        mem[5]  = 16'h0040;
        mem[6]  = 16'h1234;
        mem[7]  = 16'h5555;
        mem[10] = 16'h9C23;
        mem[11] = 16'h0000;
        mem[16'h41] = 16'h9000;
        mem[16'h42] = 16'h0100;
        mem[16'h3FFF] = 16'h0000;
        #1 reset_n = 1'b0;

        @(negedge clk);
        #3;
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_run", 32'(instruction_running), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        #3;
        check("flush_valid", 32'(issue_valid), 32'd0);
        check("flush_run", 32'(instruction_running), 32'd0);

        idle();
        check("nop_valid", 32'(issue_valid), 32'd1);
        check("nop_pc", 32'(issue_pc), 32'h0);
        idle();
        check("e005_instr", 32'(issue_instr), 32'hE005);
        check("e005_pc", 32'(issue_pc), 32'h1);
        idle();
        idle();
        check("pc3_instr", 32'(issue_instr), 32'h2311);
        idle();
        check("jmp_latch_valid", 32'(issue_valid), 32'd0);
        idle();
        check("jmp_instr", 32'(issue_instr), 32'h940C);
        check("jmp_ext", 32'(issue_ext), 32'h0040);
        check("jmp_pc", 32'(issue_pc), 32'h4);
        step(0, 1, 14'h40, 0, 5'd0, 0);
        check("br_ovw", 32'(PC_overwrite), 32'd1);
        check("br_pcnew", 32'(PC_new), 32'h40);
        step(0, 1, 14'h100, 0, 5'd0, 0);
        check("flush_br_ign", 32'(PC_overwrite), 32'd0);
        idle();
        check("tgt_pc", 32'(issue_pc), 32'h40);
        idle();
        step(1, 1, 14'h200, 0, 5'd0, 0);
        check("w2_busy_run", 32'(instruction_running), 32'd1);
        check("w2_br_ign", 32'(PC_overwrite), 32'd0);
        idle();
        check("lds_instr", 32'(issue_instr), 32'h9000);
        check("lds_ext", 32'(issue_ext), 32'h0100);
        check("lds_pc", 32'(issue_pc), 32'h41);
        step(0, 1, 14'd10, 0, 5'd0, 0);
        check("br10_pcnew", 32'(PC_new), 32'd10);
        idle();
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 14'd0, 0, 5'd0, 0);
            check("busy_run", 32'(instruction_running), 32'd1);
            check("busy_pc_hold", 32'(pc_q), 32'd11);
        end
        step(0, 0, 14'd0, 1, 5'd3, 0);
        check("mul_instr", 32'(issue_instr), 32'h9C23);
        check("mul_pc", 32'(issue_pc), 32'd10);
        check("ie0_noack", 32'(irq_ack), 32'd0);
        step(0, 1, 14'h20, 1, 5'd3, 1);
        check("br_irq_pcnew", 32'(PC_new), 32'h20);
        check("br_irq_noack", 32'(irq_ack), 32'd0);
        step(0, 0, 14'd0, 1, 5'd3, 1);
        check("flush_irq_noack", 32'(irq_ack), 32'd0);
        step(0, 0, 14'd0, 1, 5'd3, 1);
`ifdef FETCH_IRQ_EN
        check("irq_ack", 32'(irq_ack), 32'd1);
        check("irq_vec", 32'(PC_new), 32'h6);
        check("irq_ret", 32'(irq_ret_pc), 32'h20);
        check("irq_noissue", 32'(issue_valid), 32'd0);
`else
        check("irq_off_ack", 32'(irq_ack), 32'd0);
        check("irq_off_issue", 32'(issue_pc), 32'h20);
`endif
        idle();
        step(0, 1, 14'h3FFF, 0, 5'd0, 0);
        idle();
        idle();
        check("wrap_valid", 32'(issue_valid), 32'd1);
        check("wrap_ipc", 32'(issue_pc), 32'h3FFF);
        check("wrap_pc", 32'(pc_q), 32'h0);
        step(0, 1, 14'd4, 0, 5'd0, 0);
        idle();
        idle();
        step(1, 0, 14'd0, 0, 5'd0, 0);
        check("w2_hold_run", 32'(instruction_running), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst", 32'(|{instruction_running, PC_overwrite, PC_new,
              issue_valid, issue_instr, issue_ext, issue_pc, irq_ack,
              irq_ret_pc}), 32'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        check("rel_flush", 32'(issue_valid), 32'd0);
        idle();
        check("rel_issue", 32'(issue_valid), 32'd1);
        check("rel_pc", 32'(issue_pc), 32'h0);
        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
